// File: rtl/cpu6_dmem_resp_pkg.sv
// ----------------------------------------------------------------------------
// cpu6_dmem_resp_pkg
//   Shared constants and types for the CPU6 data-memory responder.
//   Constants:
//     CPU6_XLEN            data/address width
//     CPU6_DMEM_AW         SRAM word-index width (2^AW words)
//     CPU6_DMEM_SB_DEPTH   store-buffer entries (power of 2, >= 2)
//   Types:
//     cpu6_dmem_state_e    responder FSM state (IDLE, RD)
//   Optional feature macro used by the top: CPU6_DMEM_SB_FWD_EN.
// ----------------------------------------------------------------------------
package cpu6_dmem_resp_pkg;

    localparam int CPU6_XLEN          = 32;
    localparam int CPU6_DMEM_AW       = 10;
    localparam int CPU6_DMEM_SB_DEPTH = 4;

    typedef enum logic [0:0] {
        CPU6_DMEM_ST_IDLE = 1'b0,
        CPU6_DMEM_ST_RD   = 1'b1
    } cpu6_dmem_state_e;

endpackage

// File: rtl/cpu6_dmem_resp_if.sv
// ----------------------------------------------------------------------------
// cpu6_dmem_resp_if
//   MEM-stage load/store bus between the CPU6 pipeline and the data-memory
//   responder.
//   Signals:
//     memreadM    load request (held by the CPU while stallM=1)
//     memwriteM   store request (never together with memreadM)
//     dataaddrM   byte address
//     writedataM  store data
//     readdataM   load data, valid in the completing cycle (stallM=0), else 0
//     stallM      1 = CPU must hold the MEM stage this cycle
//   Handshake: a request is accepted in the cycle it is presented with
//   stallM=0; while stallM=1 the CPU keeps every request signal stable.
//   Modports: master (CPU side), slave (responder side).
// ----------------------------------------------------------------------------
interface cpu6_dmem_resp_if #(
    parameter int XLEN = 32
);
    logic            memreadM;
    logic            memwriteM;
    logic [XLEN-1:0] dataaddrM;
    logic [XLEN-1:0] writedataM;
    logic [XLEN-1:0] readdataM;
    logic            stallM;

    modport master (
        output memreadM, memwriteM, dataaddrM, writedataM,
        input  readdataM, stallM
    );

    modport slave (
        input  memreadM, memwriteM, dataaddrM, writedataM,
        output readdataM, stallM
    );
endinterface

// File: rtl/cpu6_dmem_resp_sram.sv
// ----------------------------------------------------------------------------
// cpu6_dmem_resp_sram
//   Single-port synchronous SRAM. Read data is registered on the read edge
//   and held until the next read. Contents are not reset.
//   Ports:
//     clk      clock, rising edge
//     re_i     read enable
//     we_i     write enable (never together with re_i)
//     addr_i   word index
//     wdata_i  write data
//     rdata_o  registered read data
// ----------------------------------------------------------------------------
module cpu6_dmem_resp_sram #(
    parameter int XLEN = 32,
    parameter int AW   = 10
) (
    input  logic            clk,
    input  logic            re_i,
    input  logic            we_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] rdata_o
);
    logic [XLEN-1:0] mem_q [2**AW];
    logic [XLEN-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/cpu6_dmem_resp.sv
// ----------------------------------------------------------------------------
// cpu6_dmem_resp
//   Data-memory responder for the CPU6 MEM stage. Stores are posted into a
//   circular store buffer (SB) and drained lazily, one per cycle, into a
//   synchronous-read SRAM. Loads cost one stall cycle (SRAM read) or none on
//   a store-buffer forward hit.
//   Ports:
//     clk    clock, rising edge
//     reset  asynchronous, active-high reset
//     bus    cpu6_dmem_resp_if.slave (memreadM, memwriteM, dataaddrM,
//            writedataM in; readdataM, stallM out)
//   Optional feature: define CPU6_DMEM_SB_FWD_EN to forward loads from the
//   SB. Without it a load first drains the whole SB, then reads the SRAM.
// ----------------------------------------------------------------------------
module cpu6_dmem_resp
    import cpu6_dmem_resp_pkg::*;
#(
    parameter int XLEN     = CPU6_XLEN,
    parameter int AW       = CPU6_DMEM_AW,
    parameter int SB_DEPTH = CPU6_DMEM_SB_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu6_dmem_resp_if.slave      bus
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = $clog2(SB_DEPTH + 1);

    cpu6_dmem_state_e state_q, state_d;

    logic [AW-1:0]    sb_addr_q [SB_DEPTH];
    logic [XLEN-1:0]  sb_data_q [SB_DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;

    logic             sb_full, sb_empty;
    logic [AW-1:0]    req_idx;
    logic             enq, drn, drain_req;
    logic             sram_re;
    logic [AW-1:0]    sram_addr;
    logic [XLEN-1:0]  sram_dout;
    logic             stall;
    logic [XLEN-1:0]  rdata;

    // Address bits outside the word index are deliberately ignored (aliasing).
    logic             unused_addr_bits;
    assign unused_addr_bits = ^{bus.dataaddrM[XLEN-1:AW+2], bus.dataaddrM[1:0]};

    assign req_idx  = bus.dataaddrM[AW+1:2];
    assign sb_full  = (count_q == CNT_W'(SB_DEPTH));
    assign sb_empty = (count_q == '0);

`ifdef CPU6_DMEM_SB_FWD_EN
    logic             fwd_hit;
    logic [XLEN-1:0]  fwd_data;
    logic [PTR_W-1:0] fwd_slot;

    // Walk from oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_slot = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            fwd_slot = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (sb_addr_q[fwd_slot] == req_idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data_q[fwd_slot];
            end
        end
    end
`endif

    // FSM next state, bus outputs, enqueue and drain arbitration.
    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        rdata     = '0;
        sram_re   = 1'b0;
        enq       = 1'b0;
        drain_req = 1'b0;
        if (!reset) begin
            case (state_q)
                CPU6_DMEM_ST_IDLE: begin
                    if (bus.memreadM) begin
`ifdef CPU6_DMEM_SB_FWD_EN
                        if (fwd_hit) begin
                            rdata = fwd_data;
                        end else begin
                            sram_re = 1'b1;
                            stall   = 1'b1;
                            state_d = CPU6_DMEM_ST_RD;
                        end
                        drain_req = sb_full;
`else
                        // The load waits until every posted store has landed.
                        if (!sb_empty) begin
                            stall     = 1'b1;
                            drain_req = 1'b1;
                        end else begin
                            sram_re = 1'b1;
                            stall   = 1'b1;
                            state_d = CPU6_DMEM_ST_RD;
                        end
`endif
                    end else if (bus.memwriteM) begin
                        if (sb_full) begin
                            stall     = 1'b1;
                            drain_req = 1'b1;
                        end else begin
                            enq = 1'b1;
                        end
                    end else begin
                        drain_req = 1'b1;
                    end
                end
                CPU6_DMEM_ST_RD: begin
                    rdata     = sram_dout;
                    state_d   = CPU6_DMEM_ST_IDLE;
                    drain_req = sb_full || (!bus.memreadM && !bus.memwriteM);
                end
                default: begin
                    state_d = CPU6_DMEM_ST_IDLE;
                end
            endcase
        end
    end

    // The SRAM port never reads and writes in the same cycle.
    assign drn       = drain_req && !sb_empty && !sram_re;
    assign sram_addr = sram_re ? req_idx : sb_addr_q[head_q];

    assign bus.stallM    = stall;
    assign bus.readdataM = rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CPU6_DMEM_ST_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (enq) begin
                tail_q <= tail_q + 1'b1;
            end
            if (drn) begin
                head_q <= head_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(enq) - CNT_W'(drn);
        end
    end

    // Entry storage needs no reset: count_q alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            sb_addr_q[tail_q] <= req_idx;
            sb_data_q[tail_q] <= bus.writedataM;
        end
    end

    cpu6_dmem_resp_sram #(
        .XLEN (XLEN),
        .AW   (AW)
    ) u_sram (
        .clk     (clk),
        .re_i    (sram_re),
        .we_i    (drn),
        .addr_i  (sram_addr),
        .wdata_i (sb_data_q[head_q]),
        .rdata_o (sram_dout)
    );
endmodule
